llc_set_ctrl: RTL and testbench
===============================

Name: llc_set_ctrl

Overview:
- Sequences one lookup at a time through the last-level cache tag/state array.
- Geometry: 16 MB, 16-way, 64 B lines, 32-bit address.
- Per request: reads the set, compares tags, maintains 15-bit tree pseudo-LRU, picks a victim, runs dirty write-back and line-fill handshakes, writes the updated set back, and reports hit/miss.
- Sits between the request front end and the tag RAM / memory interface. Also clears the tag RAM after reset.

Parameters:
- ADDR_SIZE, 32, request address width.
- ASSOCIATIVITY, 16, ways per set; fixed at 16 (PLRU tree depth 4).
- BYTE_SELECT, 6, line-offset bits (64 B line).
- SETS, 15625, number of sets (16000000/(16*64)).
- INDEX, 14, set-index bits (clog2 SETS).
- TAG_BITS, 12, ADDR_SIZE-(BYTE_SELECT+INDEX).
- PSEUDO_LRU, 15, PLRU bits per set.
- WAY_W, 14, bits per way entry: {valid, dirty, tag[11:0]}.
- SET_W, 239, set word: {plru[14:0], way15..way0}; way i at bits [14i+13:14i].

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_op  in  1  0=DATA_READ, 1=DATA_WRITE
- req_addr  in  32  byte address
- ram_rd_en  out  1  tag RAM read strobe
- ram_wr_en  out  1  tag RAM write strobe
- ram_addr  out  14  set index
- ram_wdata  out  239  set word to write
- ram_rdata  in  239  set word; valid the cycle after ram_rd_en
- wb_valid  out  1  dirty-line write-back request
- wb_ready  in  1  write-back accepted
- wb_addr  out  32  {victim tag, index, 6'b0}
- fill_valid  out  1  line-fill request
- fill_ready  in  1  fill complete
- fill_addr  out  32  {req tag, index, 6'b0}
- resp_valid  out  1  one-cycle completion pulse
- resp_hit  out  1  1=CACHE_HIT, 0=CACHE_MISS
- resp_way  out  4  way hit or allocated
- busy  out  1  not in IDLE
- hit_count  out  32  saturating hit counter
- miss_count  out  32  saturating miss counter

Behaviour:
- Reset (asynchronous, any state):
  - State goes to INIT and the init counter is cleared.
  - All strobes, valids, resp_* and counters go to 0; req_ready=0; busy=1.
  - RAM contents are untouched until the INIT sweep.
- Address split: tag=addr[31:20], index=addr[19:6]; addr[5:0] ignored.
- INIT:
  - One write per cycle: ram_wr_en=1, ram_addr=0..15624, ram_wdata=0. Takes 15625 cycles.
  - Then IDLE.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid&req_ready, latch op/addr and go to READ.
- READ: ram_rd_en=1, ram_addr=index; go to COMPARE.
- COMPARE (ram_rdata valid):
  - Hit means some way is valid with a matching tag. Multiple hits are illegal; the lowest way wins.
  - On hit: go to UPDATE.
  - On miss: pick the victim as the lowest-index invalid way, else the PLRU way.
  - If the victim is valid&dirty go to WB, else FILL.
- WB:
  - Hold wb_valid and wb_addr stable until wb_ready is sampled high, then go to FILL.
- FILL:
  - Hold fill_valid until fill_ready is sampled high, then go to UPDATE.
  - Zero-wait ready: WB and FILL each take exactly one cycle.
- UPDATE:
  - ram_wr_en=1 with the modified set word.
  - On hit: the hit way's dirty bit |= op.
  - On miss: the victim way becomes {1, op, req_tag}.
  - PLRU is updated for the accessed way. Go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle with resp_hit and resp_way.
  - Increment hit_count or miss_count; both saturate at 0xFFFFFFFF.
  - Go to IDLE.
- Latency, request accepted at cycle T: READ T+1, COMPARE T+2, UPDATE T+3 on hit, resp_valid at T+4, req_ready high again at T+5.
  - Clean miss with zero-wait fill: resp_valid at T+5.
  - Dirty miss with zero-wait wb/fill: resp_valid at T+6.
- PLRU tree:
  - Node 0 is the root; node n has children 2n+1 and 2n+2; plru[n] is node n.
  - Way bits w[3]..w[0] select the path from the root down.
  - Victim: at each node, take the left branch if the bit is 0, else the right branch.
  - Update on access: each node on the path is set to point away from the accessed way (1 if the path went left, 0 if right).
- No request is accepted outside IDLE. Requests presented while busy stall with req_ready=0.

Test Plan:
- Reset, then wait → ram_wr_en high exactly 15625 cycles, addresses 0..15624, all wdata 0; req_ready rises the cycle after the final write.
- Read 0x0000_1040 after INIT → READ at index 0x041, fill_addr=0x0000_1040, resp_hit=0, resp_way=0, miss_count=1. Repeat the same read → resp_hit=1, resp_way=0, resp_valid at T+4, hit_count=1.
- Reads to addresses (t<<20)|0x1040 for t=0..15 → ways 0..15 allocated in order. Read t=16 → victim way 0, no wb (clean), resp_way=0.
- Write to t=0 (dirty), fill ways 1..15, then read t=16 → wb_valid with wb_addr=0x0000_1040 before fill_valid. Hold wb_ready low 5 cycles → wb_addr stable; resp_valid at T+11.
- Assert rst mid-FILL → fill_valid and resp_valid drop immediately, counters read 0, state re-enters INIT at ram_addr 0.
- Force hit_count to 0xFFFFFFFF via repeated hits (bench may preload via force) → one more hit leaves it at 0xFFFFFFFF.

Source files
------------

// File: rtl/llc_set_ctrl.sv
// Last-level cache set controller: one lookup at a time through the tag/state array,
// 16-way tree PLRU replacement, dirty write-back, line fill and a post-reset clearing sweep.
//
// state     | meaning
// S_INIT    | writing an all-zero set word to every index after reset
// S_IDLE    | waiting for a request
// S_READ    | tag RAM read strobe for the latched index
// S_COMPARE | ram_rdata valid: tag compare, victim choice
// S_WB      | dirty victim write-back handshake
// S_FILL    | line-fill handshake
// S_UPDATE  | writing the modified set word back
// S_RESP    | one-cycle response pulse, hit/miss counters advance

module llc_set_ctrl #(
   parameter int ADDR_SIZE     = 32,
   parameter int ASSOCIATIVITY = 16,
   parameter int BYTE_SELECT   = 6,
   parameter int SETS          = 15625,
   parameter int INDEX         = 14,
   parameter int TAG_BITS      = 12,
   parameter int PSEUDO_LRU    = 15,
   parameter int WAY_W         = 14,
   parameter int SET_W         = 239
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_op,
   input  logic [ADDR_SIZE-1:0] req_addr,
   output logic                 ram_rd_en,
   output logic                 ram_wr_en,
   output logic [INDEX-1:0]     ram_addr,
   output logic [SET_W-1:0]     ram_wdata,
   input  logic [SET_W-1:0]     ram_rdata,
   output logic                 wb_valid,
   input  logic                 wb_ready,
   output logic [ADDR_SIZE-1:0] wb_addr,
   output logic                 fill_valid,
   input  logic                 fill_ready,
   output logic [ADDR_SIZE-1:0] fill_addr,
   output logic                 resp_valid,
   output logic                 resp_hit,
   output logic [3:0]           resp_way,
   output logic                 busy,
   output logic [31:0]          hit_count,
   output logic [31:0]          miss_count
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_READ,
      S_COMPARE,
      S_WB,
      S_FILL,
      S_UPDATE,
      S_RESP
   } state_t;

   state_t               state_q, state_d;
   logic [INDEX-1:0]     init_cnt_q;
   logic                 init_done;
   logic                 op_q;
   logic [TAG_BITS-1:0]  tag_q;
   logic [INDEX-1:0]     idx_q;
   logic [SET_W-1:0]     set_q;
   logic                 hit_q;
   logic [3:0]           way_q;
   logic [TAG_BITS-1:0]  victim_tag_q;
   logic [31:0]          hit_cnt_q;
   logic [31:0]          miss_cnt_q;

   logic                 cmp_hit;
   logic [3:0]           cmp_hit_way;
   logic                 inv_found;
   logic [3:0]           inv_way;
   logic [3:0]           victim_way;
   logic [WAY_W-1:0]     victim_entry;
   logic                 old_dirty;
   logic [SET_W-1:0]     upd_set;
   logic                 unused_addr_bits;

   assign unused_addr_bits = ^req_addr[BYTE_SELECT-1:0];

   function automatic logic [3:0] plru_victim(input logic [PSEUDO_LRU-1:0] p);
      int         node;
      logic [3:0] w;
      node = 0;
      w    = '0;
      for (int l = 0; l < 4; l++) begin
         w[3-l] = p[node];
         node   = 2 * node + 1 + int'(p[node]);
      end
      return w;
   endfunction

   // Every node on the accessed path is pointed away from the accessed way.
   function automatic logic [PSEUDO_LRU-1:0] plru_touch(input logic [PSEUDO_LRU-1:0] p,
                                                        input logic [3:0] w);
      int                    node;
      logic [PSEUDO_LRU-1:0] q;
      node = 0;
      q    = p;
      for (int l = 0; l < 4; l++) begin
         q[node] = ~w[3-l];
         node    = 2 * node + 1 + int'(w[3-l]);
      end
      return q;
   endfunction

   assign init_done = (init_cnt_q == INDEX'(SETS - 1));

   // Descending scan so the lowest matching / lowest invalid way wins.
   always_comb begin
      cmp_hit     = 1'b0;
      cmp_hit_way = '0;
      inv_found   = 1'b0;
      inv_way     = '0;
      for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
         if (ram_rdata[i*WAY_W + WAY_W - 1] &&
             (ram_rdata[i*WAY_W +: TAG_BITS] == tag_q)) begin
            cmp_hit     = 1'b1;
            cmp_hit_way = 4'(i);
         end
         if (!ram_rdata[i*WAY_W + WAY_W - 1]) begin
            inv_found = 1'b1;
            inv_way   = 4'(i);
         end
      end
      victim_way   = inv_found ? inv_way : plru_victim(ram_rdata[SET_W-1 -: PSEUDO_LRU]);
      victim_entry = ram_rdata[int'(victim_way)*WAY_W +: WAY_W];
   end

   always_comb begin
      upd_set   = set_q;
      old_dirty = set_q[int'(way_q)*WAY_W + WAY_W - 2];
      if (hit_q) begin
         upd_set[int'(way_q)*WAY_W +: WAY_W] = {1'b1, old_dirty | op_q, tag_q};
      end else begin
         upd_set[int'(way_q)*WAY_W +: WAY_W] = {1'b1, op_q, tag_q};
      end
      upd_set[SET_W-1 -: PSEUDO_LRU] = plru_touch(set_q[SET_W-1 -: PSEUDO_LRU], way_q);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:    if (init_done) state_d = S_IDLE;
         S_IDLE:    if (req_valid) state_d = S_READ;
         S_READ:    state_d = S_COMPARE;
         S_COMPARE: begin
            if (cmp_hit) begin
               state_d = S_UPDATE;
            end else if (victim_entry[WAY_W-1] && victim_entry[WAY_W-2]) begin
               state_d = S_WB;
            end else begin
               state_d = S_FILL;
            end
         end
         S_WB:      if (wb_ready) state_d = S_FILL;
         S_FILL:    if (fill_ready) state_d = S_UPDATE;
         S_UPDATE:  state_d = S_RESP;
         S_RESP:    state_d = S_IDLE;
         default:   state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_INIT;
         init_cnt_q   <= '0;
         op_q         <= 1'b0;
         tag_q        <= '0;
         idx_q        <= '0;
         set_q        <= '0;
         hit_q        <= 1'b0;
         way_q        <= '0;
         victim_tag_q <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_INIT: begin
               if (!init_done) init_cnt_q <= init_cnt_q + INDEX'(1);
            end
            S_IDLE: begin
               if (req_valid) begin
                  op_q  <= req_op;
                  tag_q <= req_addr[ADDR_SIZE-1 -: TAG_BITS];
                  idx_q <= req_addr[BYTE_SELECT +: INDEX];
               end
            end
            S_COMPARE: begin
               set_q        <= ram_rdata;
               hit_q        <= cmp_hit;
               way_q        <= cmp_hit ? cmp_hit_way : victim_way;
               victim_tag_q <= victim_entry[TAG_BITS-1:0];
            end
            S_RESP: begin
               if (hit_q) begin
                  if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
               end else begin
                  if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // The sweep strobe is held off while reset is asserted even though the state already reads INIT.
   assign ram_wr_en  = ((state_q == S_INIT) && !rst) || (state_q == S_UPDATE);
   assign ram_rd_en  = (state_q == S_READ);
   assign ram_addr   = (state_q == S_INIT) ? init_cnt_q : idx_q;
   assign ram_wdata  = (state_q == S_INIT) ? '0 : upd_set;
   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign wb_valid   = (state_q == S_WB);
   assign fill_valid = (state_q == S_FILL);
   assign resp_valid = (state_q == S_RESP);
   assign wb_addr    = {victim_tag_q, idx_q, {BYTE_SELECT{1'b0}}};
   assign fill_addr  = {tag_q, idx_q, {BYTE_SELECT{1'b0}}};
   assign resp_hit   = hit_q;
   assign resp_way   = way_q;
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_llc_set_ctrl.sv
// Directed bench for llc_set_ctrl: a behavioural tag RAM with one-cycle read latency
// plus zero-wait or stalled write-back / fill responders driven from each scenario task.

module tb_llc_set_ctrl;

   logic         clk;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic         req_op;
   logic [31:0]  req_addr;
   logic         ram_rd_en;
   logic         ram_wr_en;
   logic [13:0]  ram_addr;
   logic [238:0] ram_wdata;
   logic [238:0] ram_rdata;
   logic         wb_valid;
   logic         wb_ready;
   logic [31:0]  wb_addr;
   logic         fill_valid;
   logic         fill_ready;
   logic [31:0]  fill_addr;
   logic         resp_valid;
   logic         resp_hit;
   logic [3:0]   resp_way;
   logic         busy;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   logic [238:0] mem [0:15624];
   int           cyc   = 0;
   int           n_cmp = 0;
   int           n_bad = 0;

   // results of the most recent run_req
   int           r_lat;
   int           r_rd_cyc;
   logic [13:0]  r_rd_addr;
   logic         r_hit;
   logic [3:0]   r_way;
   logic         r_saw_wb;
   logic [31:0]  r_wb_addr;
   logic         r_wb_stable;
   logic         r_saw_fill;
   logic         r_fill_after_wb;
   logic [31:0]  r_fill_addr;
   logic         r_ready_busy;

   llc_set_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .ram_rd_en  (ram_rd_en),
      .ram_wr_en  (ram_wr_en),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_addr    (wb_addr),
      .fill_valid (fill_valid),
      .fill_ready (fill_ready),
      .fill_addr  (fill_addr),
      .resp_valid (resp_valid),
      .resp_hit   (resp_hit),
      .resp_way   (resp_way),
      .busy       (busy),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial ram_rdata = '0;
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_addr] <= ram_wdata;
      if (ram_rd_en) ram_rdata <= mem[ram_addr];
   end

   // Issues one request and records what happens until resp_valid; r_lat stays -1 on timeout.
   task automatic run_req(input logic op, input logic [31:0] addr, input int wb_hold);
      int t0;
      int wb_n;
      r_lat = -1; r_rd_cyc = -1; r_rd_addr = '0; r_hit = 1'b0; r_way = '0;
      r_saw_wb = 1'b0; r_wb_addr = '0; r_wb_stable = 1'b1; r_saw_fill = 1'b0;
      r_fill_after_wb = 1'b0; r_fill_addr = '0; r_ready_busy = 1'b0;
      t0 = -1; wb_n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = addr;
      for (int k = 0; k < 50; k++) begin
         if (req_ready) begin
            t0 = cyc;
            break;
         end
         @(negedge clk);
      end
      if (t0 < 0) begin
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (ram_rd_en) begin
            r_rd_cyc  = cyc - t0;
            r_rd_addr = ram_addr;
         end
         if (req_ready) r_ready_busy = 1'b1;
         if (wb_valid) begin
            if (!r_saw_wb) r_wb_addr = wb_addr;
            else if (wb_addr !== r_wb_addr) r_wb_stable = 1'b0;
            r_saw_wb = 1'b1;
            wb_ready = (wb_n >= wb_hold);
            wb_n++;
         end else begin
            wb_ready = 1'b0;
         end
         if (fill_valid) begin
            if (!r_saw_fill) begin
               r_fill_addr     = fill_addr;
               r_fill_after_wb = r_saw_wb;
            end
            r_saw_fill = 1'b1;
            fill_ready = 1'b1;
         end else begin
            fill_ready = 1'b0;
         end
         if (resp_valid) begin
            r_lat = cyc - t0;
            r_hit = resp_hit;
            r_way = resp_way;
            break;
         end
         @(negedge clk);
      end
      wb_ready   = 1'b0;
      fill_ready = 1'b0;
   endtask

   task automatic test_reset;
      int writes, addr_err, data_err, last_k, ready_k;
      rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_addr = '0;
      wb_ready = 1'b0; fill_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (ram_wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_ram_wr_en: got %b want 0", ram_wr_en); end
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %b want 1", busy); end
      n_cmp++; if ({ram_rd_en, wb_valid, fill_valid, resp_valid} !== 4'b0) begin
         n_bad++; $display("FAIL rst_strobes: got %b want 0000", {ram_rd_en, wb_valid, fill_valid, resp_valid});
      end
      n_cmp++; if ({hit_count, miss_count} !== 64'd0) begin
         n_bad++; $display("FAIL rst_counters: got %h/%h want 0/0", hit_count, miss_count);
      end
      rst = 1'b0;
      writes = 0; addr_err = 0; data_err = 0; last_k = -5; ready_k = -1;
      for (int k = 0; k < 16000; k++) begin
         #1;
         if (req_ready) begin
            ready_k = k;
            break;
         end
         if (ram_wr_en) begin
            if (ram_addr !== 14'(writes)) addr_err++;
            if (ram_wdata !== '0) data_err++;
            writes++;
            last_k = k;
         end
         @(negedge clk);
      end
      n_cmp++; if (writes != 15625) begin n_bad++; $display("FAIL init_writes: got %0d want 15625", writes); end
      n_cmp++; if (addr_err != 0) begin n_bad++; $display("FAIL init_addr_seq: got %0d bad want 0", addr_err); end
      n_cmp++; if (data_err != 0) begin n_bad++; $display("FAIL init_wdata: got %0d nonzero want 0", data_err); end
      n_cmp++; if (ready_k != last_k + 1) begin
         n_bad++; $display("FAIL init_ready_cycle: got %0d want %0d", ready_k, last_k + 1);
      end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_miss_then_hit;
      run_req(1'b0, 32'h0000_1040, 0);
      n_cmp++; if (r_rd_cyc != 1) begin n_bad++; $display("FAIL miss_read_cycle: got %0d want 1", r_rd_cyc); end
      n_cmp++; if (r_rd_addr !== 14'h041) begin n_bad++; $display("FAIL miss_read_index: got %h want 041", r_rd_addr); end
      n_cmp++; if (r_lat != 5) begin n_bad++; $display("FAIL miss_latency: got %0d want 5", r_lat); end
      n_cmp++; if (r_hit !== 1'b0) begin n_bad++; $display("FAIL miss_resp_hit: got %b want 0", r_hit); end
      n_cmp++; if (r_way !== 4'd0) begin n_bad++; $display("FAIL miss_resp_way: got %0d want 0", r_way); end
      n_cmp++; if (r_fill_addr !== 32'h0000_1040) begin
         n_bad++; $display("FAIL miss_fill_addr: got %h want 00001040", r_fill_addr);
      end
      n_cmp++; if (r_saw_wb !== 1'b0) begin n_bad++; $display("FAIL miss_no_wb: got %b want 0", r_saw_wb); end
      n_cmp++; if (r_ready_busy !== 1'b0) begin n_bad++; $display("FAIL ready_while_busy: got %b want 0", r_ready_busy); end
      @(negedge clk);
      n_cmp++; if (miss_count !== 32'd1) begin n_bad++; $display("FAIL miss_count_1: got %0d want 1", miss_count); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL resp_one_cycle: got %b want 0", resp_valid); end
      run_req(1'b0, 32'h0000_1040, 0);
      n_cmp++; if (r_lat != 4) begin n_bad++; $display("FAIL hit_latency: got %0d want 4", r_lat); end
      n_cmp++; if (r_hit !== 1'b1) begin n_bad++; $display("FAIL hit_resp_hit: got %b want 1", r_hit); end
      n_cmp++; if (r_way !== 4'd0) begin n_bad++; $display("FAIL hit_resp_way: got %0d want 0", r_way); end
      n_cmp++; if (r_saw_fill !== 1'b0) begin n_bad++; $display("FAIL hit_no_fill: got %b want 0", r_saw_fill); end
      @(negedge clk);
      n_cmp++; if (hit_count !== 32'd1) begin n_bad++; $display("FAIL hit_count_1: got %0d want 1", hit_count); end
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL hit_ready_t5: got %b want 1", req_ready); end
   endtask

   task automatic test_fill_ways;
      for (int t = 0; t < 16; t++) begin
         run_req(1'b0, (32'(t) << 20) | 32'h0000_1040, 0);
         n_cmp++; if (r_way !== 4'(t)) begin n_bad++; $display("FAIL alloc_way_t%0d: got %0d want %0d", t, r_way, t); end
         n_cmp++; if (r_hit !== (t == 0)) begin n_bad++; $display("FAIL alloc_hit_t%0d: got %b want %b", t, r_hit, t == 0); end
         n_cmp++; if (r_lat != ((t == 0) ? 4 : 5)) begin
            n_bad++; $display("FAIL alloc_lat_t%0d: got %0d want %0d", t, r_lat, (t == 0) ? 4 : 5);
         end
      end
      run_req(1'b0, 32'h0100_1040, 0);
      n_cmp++; if (r_way !== 4'd0) begin n_bad++; $display("FAIL plru_t16_way: got %0d want 0", r_way); end
      n_cmp++; if (r_hit !== 1'b0) begin n_bad++; $display("FAIL plru_t16_hit: got %b want 0", r_hit); end
      n_cmp++; if (r_saw_wb !== 1'b0) begin n_bad++; $display("FAIL plru_t16_clean: got %b want 0", r_saw_wb); end
      n_cmp++; if (r_fill_addr !== 32'h0100_1040) begin
         n_bad++; $display("FAIL plru_t16_fill_addr: got %h want 01001040", r_fill_addr);
      end
      n_cmp++; if (r_lat != 5) begin n_bad++; $display("FAIL plru_t16_lat: got %0d want 5", r_lat); end
      run_req(1'b0, 32'h0110_1040, 0);
      n_cmp++; if (r_way !== 4'd8) begin n_bad++; $display("FAIL plru_t17_way: got %0d want 8", r_way); end
   endtask

   task automatic test_dirty_wb;
      run_req(1'b1, 32'h0000_2080, 0);
      n_cmp++; if (r_way !== 4'd0) begin n_bad++; $display("FAIL wr_alloc_way: got %0d want 0", r_way); end
      n_cmp++; if (r_lat != 5) begin n_bad++; $display("FAIL wr_alloc_lat: got %0d want 5", r_lat); end
      for (int t = 1; t < 16; t++) begin
         run_req(1'b0, (32'(t) << 20) | 32'h0000_2080, 0);
         n_cmp++; if (r_way !== 4'(t)) begin n_bad++; $display("FAIL wb_fill_way_t%0d: got %0d want %0d", t, r_way, t); end
      end
      run_req(1'b0, 32'h0100_2080, 5);
      n_cmp++; if (r_saw_wb !== 1'b1) begin n_bad++; $display("FAIL dirty_wb_seen: got %b want 1", r_saw_wb); end
      n_cmp++; if (r_wb_addr !== 32'h0000_2080) begin
         n_bad++; $display("FAIL dirty_wb_addr: got %h want 00002080", r_wb_addr);
      end
      n_cmp++; if (r_wb_stable !== 1'b1) begin n_bad++; $display("FAIL dirty_wb_stable: got %b want 1", r_wb_stable); end
      n_cmp++; if (r_fill_after_wb !== 1'b1) begin n_bad++; $display("FAIL wb_before_fill: got %b want 1", r_fill_after_wb); end
      n_cmp++; if (r_fill_addr !== 32'h0100_2080) begin
         n_bad++; $display("FAIL dirty_fill_addr: got %h want 01002080", r_fill_addr);
      end
      n_cmp++; if (r_lat != 11) begin n_bad++; $display("FAIL dirty_latency: got %0d want 11", r_lat); end
      n_cmp++; if (r_way !== 4'd0) begin n_bad++; $display("FAIL dirty_way: got %0d want 0", r_way); end
      @(negedge clk);
      n_cmp++; if (miss_count !== 32'd35) begin n_bad++; $display("FAIL miss_count_35: got %0d want 35", miss_count); end
      n_cmp++; if (hit_count !== 32'd2) begin n_bad++; $display("FAIL hit_count_2: got %0d want 2", hit_count); end
   endtask

   task automatic test_reset_mid_fill;
      int seen;
      int ready_k;
      seen = 0;
      @(negedge clk);
      req_valid = 1'b1; req_op = 1'b0; req_addr = 32'h0140_1040;
      for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (fill_valid) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      n_cmp++; if (seen != 1) begin n_bad++; $display("FAIL midfill_reached: got %0d want 1", seen); end
      rst = 1'b1;
      #1;
      n_cmp++; if ({fill_valid, resp_valid} !== 2'b00) begin
         n_bad++; $display("FAIL midfill_drop: got %b want 00", {fill_valid, resp_valid});
      end
      n_cmp++; if ({hit_count, miss_count} !== 64'd0) begin
         n_bad++; $display("FAIL midfill_counters: got %h/%h want 0/0", hit_count, miss_count);
      end
      n_cmp++; if (ram_addr !== 14'd0) begin n_bad++; $display("FAIL midfill_ram_addr: got %0d want 0", ram_addr); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midfill_busy: got %b want 1", busy); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if ({ram_wr_en, ram_addr} !== {1'b1, 14'd0}) begin
         n_bad++; $display("FAIL reinit_first_write: got %b/%0d want 1/0", ram_wr_en, ram_addr);
      end
      ready_k = -1;
      for (int k = 0; k < 16000; k++) begin
         @(negedge clk);
         if (req_ready) begin
            ready_k = k;
            break;
         end
      end
      n_cmp++; if (ready_k != 15624) begin n_bad++; $display("FAIL reinit_ready: got %0d want 15624", ready_k); end
   endtask

   task automatic test_saturate;
      @(negedge clk);
      force dut.hit_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.hit_cnt_q;
      run_req(1'b0, 32'h0000_1040, 0);
      n_cmp++; if (r_hit !== 1'b0) begin n_bad++; $display("FAIL sat_first_miss: got %b want 0", r_hit); end
      @(negedge clk);
      n_cmp++; if (miss_count !== 32'd1) begin n_bad++; $display("FAIL sat_miss_count: got %0d want 1", miss_count); end
      n_cmp++; if (hit_count !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL sat_preload: got %h want fffffffe", hit_count); end
      run_req(1'b0, 32'h0000_1040, 0);
      @(negedge clk);
      n_cmp++; if (hit_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_reach_max: got %h want ffffffff", hit_count); end
      run_req(1'b1, 32'h0000_1040, 0);
      n_cmp++; if (r_hit !== 1'b1) begin n_bad++; $display("FAIL sat_write_hit: got %b want 1", r_hit); end
      @(negedge clk);
      n_cmp++; if (hit_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_hold_max: got %h want ffffffff", hit_count); end
   endtask

   initial begin
      test_reset();
      test_miss_then_hit();
      test_fill_ways();
      test_dirty_wb();
      test_reset_mid_fill();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: got still running want finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
